// File: rtl/data_mem_responder.sv
// Load/store responder on a word-organised RAM with programmable wait states and RISC-V lane handling.
// Define MISALIGN_TRAP_EN to report misaligned or illegal accesses on rsp_err instead of aligning them.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbgState
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Handshake: a request transfers on an edge where req_valid && req_ready; a response
  // transfers on an edge where rsp_valid && rsp_ready. Both ready/valid outputs are registered.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} stateT;

  stateT             state;
  logic              capWe;
  logic [IDX_W+1:0]  capAddr;
  logic [2:0]        capType;
  logic [31:0]       capWdata;
  logic [3:0]        cnt;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  wordIdx;
  logic [31:0]       memWord;
  logic [7:0]        loByte;
  logic [15:0]       loHalf;
  logic [31:0]       loadData;
  logic [3:0]        wMask;
  logic [31:0]       wData;
  logic              accErr;
  logic              doAccess;
  logic              doWrite;

  // Upper address bits wrap silently, so they are intentionally dropped.
  logic unusedAddr;
  assign unusedAddr = ^req_addr[31:IDX_W+2];

  assign wordIdx  = capAddr[IDX_W+1:2];
  assign memWord  = mem[wordIdx];
  assign dbgState = state;
  assign doAccess = (state == WAIT) && (cnt == 4'd0);
  assign doWrite  = doAccess && capWe && !accErr;

  always_comb begin
    accErr = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (capType)
      3'b001, 3'b101:         accErr = capAddr[0];
      3'b010:                 accErr = |capAddr[1:0];
      3'b011, 3'b110, 3'b111: accErr = 1'b1;
      default:                accErr = 1'b0;
    endcase
`endif
    case (capAddr[1:0])
      2'd0:    loByte = memWord[7:0];
      2'd1:    loByte = memWord[15:8];
      2'd2:    loByte = memWord[23:16];
      default: loByte = memWord[31:24];
    endcase
    loHalf = capAddr[1] ? memWord[31:16] : memWord[15:0];
    case (capType)
      3'b000:  loadData = {{24{loByte[7]}}, loByte};
      3'b100:  loadData = {24'd0, loByte};
      3'b001:  loadData = {{16{loHalf[15]}}, loHalf};
      3'b101:  loadData = {16'd0, loHalf};
      default: loadData = memWord;
    endcase
    // Store data is replicated across lanes so the mask alone picks the target bytes.
    case (capType)
      3'b000, 3'b100: begin
        wMask = 4'b0001 << capAddr[1:0];
        wData = {4{capWdata[7:0]}};
      end
      3'b001, 3'b101: begin
        wMask = capAddr[1] ? 4'b1100 : 4'b0011;
        wData = {2{capWdata[15:0]}};
      end
      default: begin
        wMask = 4'b1111;
        wData = capWdata;
      end
    endcase
  end

  // RAM is never reset; reset forces the FSM out of WAIT asynchronously, which blocks the write.
  always_ff @(posedge CLK) begin
    if (doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (wMask[b]) mem[wordIdx][8*b +: 8] <= wData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
      capWe     <= 1'b0;
      capAddr   <= '0;
      capType   <= 3'd0;
      capWdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            capWe     <= req_we;
            capAddr   <= req_addr[IDX_W+1:0];
            capType   <= req_type;
            capWdata  <= req_wdata;
            cnt       <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= (capWe || accErr) ? 32'd0 : loadData;
            rsp_err   <= accErr;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbgState(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural model: byte-addressed memory
  logic [7:0] mb [DEPTH*4];

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                              input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int a;
    int size;
    bit sgn;
    logic [31:0] v;
    a = int'(addr % 32'(DEPTH*4));
    case (typ)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: begin size = 4; sgn = 0; end
    endcase
    err = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (typ == 3'd3 || typ == 3'd6 || typ == 3'd7) err = 1'b1;
    else if (a % size != 0) err = 1'b1;
`else
    a = a - (a % size);
`endif
    rdata = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[a+i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[a+i]) << (8*i));
      if (sgn && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
      rdata = v;
    end
  endtask

  // scoreboard
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_at_q[$];
  bit          in_resp = 0;
  logic [31:0] held;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          hs_cyc = -1;
  int          last_acc = 0;

  always @(negedge CLK) begin
    if (RESET) begin
      in_resp = 0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        if (!in_resp) begin
          check32("rsp_latency", 32'(cyc), 32'(exp_at_q[0]));
          in_resp = 1;
          held = rsp_rdata;
        end else begin
          check32("rsp_hold", rsp_rdata, held);
        end
        check32("rsp_rdata", rsp_rdata, exp_q[0]);
        check32("rsp_err", 32'(rsp_err), 32'(exp_err_q[0]));
        check32("req_ready_busy", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          last_rdata = rsp_rdata;
          last_err = rsp_err;
          hs_cyc = cyc;
          void'(exp_q.pop_front());
          void'(exp_err_q.pop_front());
          void'(exp_at_q.pop_front());
          in_resp = 0;
        end
      end
    end else if (exp_at_q.size() != 0) begin
      n_checks++;
      if (cyc >= exp_at_q[0]) begin
        n_fail++;
        $display("FAIL rsp_missing: got rsp_valid=0 expected 1 by cycle %0d (cycle %0d)", exp_at_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
        void'(exp_at_q.pop_front());
      end
    end
  end

  // response backpressure: 0 random, 1 forced low, 2 forced high
  int bp_mode = 0;
  always @(posedge CLK) begin
    #1;
    case (bp_mode)
      1: rsp_ready = 1'b0;
      2: rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // driver tasks
  task automatic send(input logic we, input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] wdata);
    logic [31:0] r;
    logic e;
    int acc;
    bit ok;
    ok = 0;
    acc = 0;
    @(posedge CLK);
    #1;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_type = typ;
    req_wdata = wdata;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1;
        acc = cyc;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 300 cycles");
      req_valid = 1'b0;
      return;
    end
    last_acc = acc;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    model_access(we, addr, typ, wdata, r, e);
    exp_q.push_back(r);
    exp_err_q.push_back(e);
    exp_at_q.push_back(acc + LAT + 2);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic load_lit(input string name, input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] lit);
    send(1'b0, addr, typ, 32'd0);
    wait_done();
    check32(name, last_rdata, lit);
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, 8'hC3, k ^ 8'h5A, 8'h3C};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check32("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("reset_req_ready", 32'(req_ready), 32'd1);
    check32("reset_rsp_rdata", rsp_rdata, 32'd0);
    check32("reset_rsp_err", 32'(rsp_err), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 32; i++) send(1'b1, 32'(i*4), 3'b010, init_word(i));
    wait_done();

    send(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    wait_done();
    load_lit("lw_deadbeef", 32'h10, 3'b010, 32'hDEADBEEF);
    send(1'b1, 32'h11, 3'b000, 32'h00000080);
    wait_done();
    load_lit("lb_11", 32'h11, 3'b000, 32'hFFFFFF80);
    load_lit("lbu_11", 32'h11, 3'b100, 32'h00000080);
    load_lit("lw_after_sb", 32'h10, 3'b010, 32'hDEAD80EF);
    load_lit("lh_12", 32'h12, 3'b001, 32'hFFFFDEAD);

    // backpressure: response held, second request blocked
    bp_mode = 1;
    send(1'b0, 32'h10, 3'b010, 32'd0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLK);
    @(posedge CLK);
    #1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h14;
    req_type = 3'b010;
    repeat (5) begin
      @(negedge CLK);
      check32("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check32("bp_req_ready", 32'(req_ready), 32'd0);
      check32("bp_rsp_rdata", rsp_rdata, 32'hDEAD80EF);
    end
    bp_mode = 2;
    send(1'b0, 32'h14, 3'b010, 32'd0);
    check32("bp_accept_after_hs", 32'(last_acc > hs_cyc), 32'd1);
    wait_done();
    check32("bp_second_rdata", last_rdata, 32'h05C35F3C);
    bp_mode = 0;

    send(1'b1, 32'h1000, 3'b010, 32'h12345678);
    wait_done();
    load_lit("wrap_lw_0", 32'h0, 3'b010, 32'h12345678);
    load_lit("wrap_lw_1004", 32'h1004, 3'b010, 32'h01C35B3C);

    // reset while the store waits: no write, no response
    @(posedge CLK);
    #1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h20;
    req_type = 3'b010;
    req_wdata = 32'hFFFFFFFF;
    @(negedge CLK);
    check32("rst_wait_ready", 32'(req_ready), 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check32("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rst_wait_req_ready", 32'(req_ready), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    load_lit("rst_wait_no_write", 32'h20, 3'b010, 32'h08C3523C);

`ifdef MISALIGN_TRAP_EN
    send(1'b0, 32'h22, 3'b010, 32'd0);
    wait_done();
    check32("trap_lw_err", 32'(last_err), 32'd1);
    check32("trap_lw_rdata", last_rdata, 32'd0);
    send(1'b1, 32'h21, 3'b001, 32'h0000BEEF);
    wait_done();
    check32("trap_sh_err", 32'(last_err), 32'd1);
    load_lit("trap_sh_no_write", 32'h20, 3'b010, 32'h08C3523C);
`else
    load_lit("lh_misaligned", 32'h21, 3'b001, 32'h0000523C);
    check32("lh_misaligned_err", 32'(last_err), 32'd0);
    load_lit("type7_as_w", 32'h24, 3'b111, 32'h09C3533C);
`endif

    for (int n = 0; n < 300; n++) begin
      send(1'($urandom_range(0, 1)), ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 127)),
           3'($urandom_range(0, 7)), $urandom());
      if ($urandom_range(0, 7) == 0) wait_done();
    end
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
